urx: RTL and testbench

- UART receiver; the receive-side counterpart of the utx transmitter.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous serial line.
- Uses the same 2-bit baud select and clocks-per-bit table as the transmitter.
- Delivers each received byte with a one-cycle valid strobe, and flags frames whose stop bit is bad.

---
 rtl/urx_if.sv | 28 ++
 rtl/urx.sv | 170 +++++++++++++++++
 tb/tb_urx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/urx_if.sv
// Serial-line and received-data signals of the urx UART receiver.
// The slave modport is the receiver; the master modport is whatever drives the line and consumes bytes.
interface urx_if;
    logic       i_Rx_Serial;
    logic [1:0] baud_select;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Framing_Err;

    modport master (
        output i_Rx_Serial,
        output baud_select,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Active,
        input  o_Framing_Err
    );

    modport slave (
        input  i_Rx_Serial,
        input  baud_select,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Active,
        output o_Framing_Err
    );
endinterface

// File: rtl/urx.sv
// UART receiver for 8N1 frames, LSB first, with a selectable bit period.
// The line is sampled mid-bit; a low stop bit raises a one-cycle framing error instead of a valid strobe.
module urx #(
    parameter int CLKS_PER_BIT_9600  = 1042,
    parameter int CLKS_PER_BIT_19200 = 521,
    parameter int CLKS_PER_BIT_38400 = 261,
    parameter int CLKS_PER_BIT_57600 = 174
) (
    input  logic  i_Clock,
    input  logic  i_Rst_n,
    urx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_e;

    localparam logic [10:0] PERIOD_00 = 11'(CLKS_PER_BIT_9600);
    localparam logic [10:0] PERIOD_01 = 11'(CLKS_PER_BIT_19200);
    localparam logic [10:0] PERIOD_10 = 11'(CLKS_PER_BIT_38400);
    localparam logic [10:0] PERIOD_11 = 11'(CLKS_PER_BIT_57600);

    state_e      state_q,  state_d;
    logic [1:0]  sync_q,   sync_d;
    logic [10:0] period_q, period_d;
    logic [10:0] cnt_q,    cnt_d;
    logic [2:0]  idx_q,    idx_d;
    logic [7:0]  shift_q,  shift_d;
    logic [7:0]  byte_q,   byte_d;
    logic        dv_q,     dv_d;
    logic        err_q,    err_d;
    logic        active_q, active_d;

    logic        rx;
    logic [10:0] period_sel;
    logic [10:0] half;

    assign rx   = sync_q[1];
    assign half = period_q >> 1;

    always_comb begin
        case (bus.baud_select)
            2'b00:   period_sel = PERIOD_00;
            2'b01:   period_sel = PERIOD_01;
            2'b10:   period_sel = PERIOD_10;
            default: period_sel = PERIOD_11;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[0], bus.i_Rx_Serial};
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                if (!rx) begin
                    // The bit period is frozen per frame so a mid-frame select change cannot skew sampling.
                    state_d  = S_START;
                    active_d = 1'b1;
                    period_d = period_sel;
                end
            end

            S_START: begin
                if (cnt_q == half - 11'd1) begin
                    cnt_d = '0;
                    if (!rx) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == period_q - 11'd1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == period_q - 11'd1) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    if (rx) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            S_CLEANUP: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            sync_q   <= 2'b11;
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign bus.o_Rx_DV       = dv_q;
    assign bus.o_Rx_Byte     = byte_q;
    assign bus.o_Rx_Active   = active_q;
    assign bus.o_Framing_Err = err_q;

endmodule

// File: tb/tb_urx.sv
// Directed bench for urx: a bit-banged 8N1 line model plus a negedge monitor that counts strobes.
// Each scenario task checks its own expectations inline against hand-derived values.
`timescale 1ns/1ps
module tb_urx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    urx_if bus();

    urx dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses and active cycles, remembers the last two received bytes.
    int          dv_cnt = 0, err_cnt = 0, both_cnt = 0;
    int          dv_wide = 0, err_wide = 0, act_rise = 0, act_hi = 0;
    int unsigned dv_cyc = 0;
    logic [7:0]  rx_seen = 8'h00, rx_prev = 8'h00;
    logic        dv_prev = 1'b0, err_prev = 1'b0, act_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.o_Rx_DV === 1'b1) begin
            dv_cnt++;
            rx_prev = rx_seen;
            rx_seen = bus.o_Rx_Byte;
            dv_cyc  = cyc;
            if (dv_prev) dv_wide++;
        end
        if (bus.o_Framing_Err === 1'b1) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        if (bus.o_Rx_DV === 1'b1 && bus.o_Framing_Err === 1'b1) both_cnt++;
        if (bus.o_Rx_Active === 1'b1) begin
            act_hi++;
            if (!act_prev) act_rise++;
        end
        dv_prev  = (bus.o_Rx_DV === 1'b1);
        err_prev = (bus.o_Framing_Err === 1'b1);
        act_prev = (bus.o_Rx_Active === 1'b1);
    end

    logic [7:0] exp_last;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; optionally switches baud_select at bit tog_bit and restores it at the stop bit.
    task automatic send_frame(input logic [7:0] d, input int n, input logic stop_v,
                              input int tog_bit, input logic [1:0] tog_val);
        logic [1:0] saved;
        saved = bus.baud_select;
        for (int b = 0; b < 10; b++) begin
            logic v;
            v = (b == 0) ? 1'b0 : ((b == 9) ? stop_v : d[b-1]);
            if (b == tog_bit) bus.baud_select = tog_val;
            if (b == 9 && tog_bit >= 0) bus.baud_select = saved;
            bus.i_Rx_Serial = v;
            wait_clks(n);
        end
        bus.i_Rx_Serial = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_Rx_Serial = 1'b1;
        bus.baud_select = 2'b11;
        wait_clks(5);
        total++; if (bus.o_Rx_DV !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", bus.o_Rx_DV); end
        total++; if (bus.o_Rx_Byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", bus.o_Rx_Byte); end
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", bus.o_Rx_Active); end
        total++; if (bus.o_Framing_Err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.o_Framing_Err); end
        rst_n = 1'b1;
        wait_clks(10);
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL idle_active: got %b want 0", bus.o_Rx_Active); end
    endtask

    task automatic test_single_frame();
        int unsigned c0;
        int dv0, err0, rise0, hi0, lat, hi;
        bus.baud_select = 2'b11;
        wait_clks(5);
        c0 = cyc; dv0 = dv_cnt; err0 = err_cnt; rise0 = act_rise; hi0 = act_hi;
        send_frame(8'hA5, 174, 1'b1, -1, 2'b00);
        wait_clks(20);
        lat = int'(dv_cyc - c0);
        hi  = act_hi - hi0;
        total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
        total++; if (bus.o_Rx_Byte !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", bus.o_Rx_Byte); end
        total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL single_err: got %0d want 0", err_cnt - err0); end
        total++; if (lat < 1654 || lat > 1658) begin bad++; $display("FAIL single_latency: got %0d want 1656+-2", lat); end
        total++; if (act_rise - rise0 !== 1) begin bad++; $display("FAIL single_active_rise: got %0d want 1", act_rise - rise0); end
        total++; if (hi < 1652 || hi > 1656) begin bad++; $display("FAIL single_active_len: got %0d want 1654+-2", hi); end
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL single_active_end: got %b want 0", bus.o_Rx_Active); end
        exp_last = 8'hA5;
    endtask

    task automatic test_loopback();
        int         periods [4] = '{1042, 521, 261, 174};
        logic [7:0] vals    [3] = '{8'h00, 8'hFF, 8'h3C};
        for (int r = 0; r < 4; r++) begin
            bus.baud_select = 2'(r);
            wait_clks(10);
            for (int k = 0; k < 3; k++) begin
                int dv0, err0;
                dv0 = dv_cnt; err0 = err_cnt;
                send_frame(vals[k], periods[r], 1'b1, -1, 2'b00);
                wait_clks(5);
                total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL loop_dv sel=%0d: got %0d want 1", r, dv_cnt - dv0); end
                total++; if (bus.o_Rx_Byte !== vals[k]) begin bad++; $display("FAIL loop_byte sel=%0d: got %h want %h", r, bus.o_Rx_Byte, vals[k]); end
                total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL loop_err sel=%0d: got %0d want 0", r, err_cnt - err0); end
                exp_last = vals[k];
            end
        end
        bus.baud_select = 2'b11;
        wait_clks(10);
    endtask

    task automatic test_framing_error();
        int dv0, err0;
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(8'h5A, 174, 1'b0, -1, 2'b00);
        wait_clks(300);
        total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", err_cnt - err0); end
        total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL ferr_dv: got %0d want 0", dv_cnt - dv0); end
        total++; if (bus.o_Rx_Byte !== exp_last) begin bad++; $display("FAIL ferr_byte_held: got %h want %h", bus.o_Rx_Byte, exp_last); end
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL ferr_active_end: got %b want 0", bus.o_Rx_Active); end
    endtask

    task automatic test_glitch();
        int dv0, err0, rise0;
        dv0 = dv_cnt; err0 = err_cnt; rise0 = act_rise;
        bus.i_Rx_Serial = 1'b0;
        wait_clks(40);
        bus.i_Rx_Serial = 1'b1;
        wait_clks(150);
        total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL glitch_dv: got %0d want 0", dv_cnt - dv0); end
        total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - err0); end
        total++; if (act_rise - rise0 !== 1) begin bad++; $display("FAIL glitch_active_pulse: got %0d want 1", act_rise - rise0); end
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL glitch_active_end: got %b want 0", bus.o_Rx_Active); end
        total++; if (bus.o_Rx_Byte !== exp_last) begin bad++; $display("FAIL glitch_byte_held: got %h want %h", bus.o_Rx_Byte, exp_last); end
    endtask

    task automatic test_reset_mid_frame();
        int         dv0, err0;
        logic [7:0] d;
        d = 8'hC3;
        dv0 = dv_cnt; err0 = err_cnt;
        bus.i_Rx_Serial = 1'b0;
        wait_clks(174);
        for (int b = 0; b < 4; b++) begin
            bus.i_Rx_Serial = d[b];
            wait_clks(174);
        end
        bus.i_Rx_Serial = d[4];
        wait_clks(87);
        total++; if (bus.o_Rx_Active !== 1'b1) begin bad++; $display("FAIL rst_active_before: got %b want 1", bus.o_Rx_Active); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.o_Rx_Active !== 1'b0) begin bad++; $display("FAIL rst_async_active: got %b want 0", bus.o_Rx_Active); end
        total++; if (bus.o_Rx_Byte !== 8'h00) begin bad++; $display("FAIL rst_async_byte: got %h want 00", bus.o_Rx_Byte); end
        total++; if (bus.o_Rx_DV !== 1'b0) begin bad++; $display("FAIL rst_async_dv: got %b want 0", bus.o_Rx_DV); end
        total++; if (bus.o_Framing_Err !== 1'b0) begin bad++; $display("FAIL rst_async_err: got %b want 0", bus.o_Framing_Err); end
        bus.i_Rx_Serial = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);
        total++; if (dv_cnt - dv0 !== 0 || err_cnt - err0 !== 0) begin bad++; $display("FAIL rst_abort_pulses: got dv=%0d err=%0d want 0/0", dv_cnt - dv0, err_cnt - err0); end
        dv0 = dv_cnt;
        send_frame(8'h81, 174, 1'b1, -1, 2'b00);
        wait_clks(20);
        total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL rst_next_dv: got %0d want 1", dv_cnt - dv0); end
        total++; if (bus.o_Rx_Byte !== 8'h81) begin bad++; $display("FAIL rst_next_byte: got %h want 81", bus.o_Rx_Byte); end
        exp_last = 8'h81;
    endtask

    task automatic test_back_to_back();
        int dv0, err0;
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(8'h12, 174, 1'b1, 4, 2'b00);
        send_frame(8'h34, 174, 1'b1, -1, 2'b00);
        wait_clks(20);
        total++; if (dv_cnt - dv0 !== 2) begin bad++; $display("FAIL b2b_dv: got %0d want 2", dv_cnt - dv0); end
        total++; if (rx_prev !== 8'h12) begin bad++; $display("FAIL b2b_first: got %h want 12", rx_prev); end
        total++; if (rx_seen !== 8'h34) begin bad++; $display("FAIL b2b_second: got %h want 34", rx_seen); end
        total++; if (bus.o_Rx_Byte !== 8'h34) begin bad++; $display("FAIL b2b_byte: got %h want 34", bus.o_Rx_Byte); end
        total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt - err0); end
    endtask

    task automatic test_pulse_rules();
        total++; if (dv_wide !== 0) begin bad++; $display("FAIL dv_width: got %0d wide pulses want 0", dv_wide); end
        total++; if (err_wide !== 0) begin bad++; $display("FAIL err_width: got %0d wide pulses want 0", err_wide); end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL dv_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        exp_last = 8'h00;
        test_reset();
        test_single_frame();
        test_loopback();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
